// File: rtl/montgomery_stream_pkg.sv
// Shared definitions for the Montgomery squarer output stream.
//   REGISTER_SIZE    : width of every data block and exponent word
//   BLOCKS_PER_VALUE : register blocks per square value
//   NUM_SQUARES      : exponent bits (squares) per exponentiation
//   EXP_WORDS        : exponent words per exponentiation
//   selector_state_t : control states of the square selector
package montgomery_stream_pkg;

  localparam int unsigned REGISTER_SIZE    = 32;
  localparam int unsigned BLOCKS_PER_VALUE = 128;
  localparam int unsigned NUM_SQUARES      = 2048;
  localparam int unsigned EXP_WORDS        = NUM_SQUARES / REGISTER_SIZE;

  typedef enum logic [1:0] {
    WAIT_EXP,
    STREAM,
    DONE
  } selector_state_t;

endpackage

// File: rtl/exponent_prefetch_buffer.sv
// Two-word exponent store: cur_word is consumed LSB first by shifting,
// next_word is a prefetch slot refilled by the upstream handshake.
//   clk_in, rst_in : clock, synchronous active-low reset
//   word           : incoming exponent word
//   word_valid     : incoming word valid
//   word_ready     : prefetch slot free (transfer on valid & ready)
//   shift          : consume cur_word bit 0
//   reload         : word boundary, move next_word into cur_word
//   cur_lsb        : bit 0 of cur_word
//   cur_full       : cur_word holds a valid word
//   next_full      : next_word holds a valid word
module exponent_prefetch_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] word,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             shift,
  input  logic             reload,
  output logic             cur_lsb,
  output logic             cur_full,
  output logic             next_full
);

  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] next_word;
  logic             xfer;
  logic             to_cur;

  assign word_ready = ~next_full;
  assign xfer       = word_valid & ~next_full;
  assign cur_lsb    = cur_word[0];
  // A transfer can only coincide with reload when next_word is empty; that
  // word is then the one cur_word needs, so it bypasses straight into cur.
  assign to_cur     = ~cur_full | reload;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cur_word  <= '0;
      next_word <= '0;
      cur_full  <= 1'b0;
      next_full <= 1'b0;
    end else begin
      if (reload) begin
        cur_word  <= next_word;
        cur_full  <= next_full;
        next_full <= 1'b0;
      end else if (shift) begin
        cur_word <= cur_word >> 1;
      end
      if (xfer) begin
        if (to_cur) begin
          cur_word <= word;
          cur_full <= 1'b1;
        end else begin
          next_word <= word;
          next_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/montgomery_square_selector_stream.sv
// Output-side consumer of the Montgomery squarer stream. Forwards square
// x^(2^i) mod N to the multiplier-accumulator only when exponent bit i is 1.
//   clk_in, rst_in        : clock, synchronous active-low reset
//   square_block_in/valid : square blocks, LSB block first, no backpressure
//   exponent_block_in/valid/ready_out : exponent words, LSB word first
//   selected_block_out/valid/last     : forwarded blocks, last tags value end
//   done_out              : pulse with the last block of the final square
//   any_selected_out      : valid with done_out, 0 means exponent was zero
//   exponent_underrun_out : sticky, exponent bits were missing
module montgomery_square_selector_stream #(
  parameter int unsigned REGISTER_SIZE    = montgomery_stream_pkg::REGISTER_SIZE,
  parameter int unsigned BLOCKS_PER_VALUE = montgomery_stream_pkg::BLOCKS_PER_VALUE,
  parameter int unsigned NUM_SQUARES      = montgomery_stream_pkg::NUM_SQUARES
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] square_block_in,
  input  logic                     square_valid_in,
  input  logic [REGISTER_SIZE-1:0] exponent_block_in,
  input  logic                     exponent_valid_in,
  output logic                     exponent_ready_out,
  output logic [REGISTER_SIZE-1:0] selected_block_out,
  output logic                     selected_valid_out,
  output logic                     selected_last_out,
  output logic                     done_out,
  output logic                     any_selected_out,
  output logic                     exponent_underrun_out
);

  import montgomery_stream_pkg::*;

  localparam int unsigned BLK_W = (BLOCKS_PER_VALUE > 1) ? $clog2(BLOCKS_PER_VALUE) : 1;
  localparam int unsigned BIT_W = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;
  localparam int unsigned SQ_W  = (NUM_SQUARES > 1) ? $clog2(NUM_SQUARES) : 1;

  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCKS_PER_VALUE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(REGISTER_SIZE - 1);
  localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(NUM_SQUARES - 1);

  selector_state_t state;
  selector_state_t state_next;

  logic [BLK_W-1:0] block_ctr;
  logic [BIT_W-1:0] bit_ctr;
  logic [SQ_W-1:0]  square_ctr;
  logic             any_acc;

  logic cur_lsb;
  logic cur_full;
  logic next_full;

  logic accept;
  logic sel_bit;
  logic value_end;
  logic word_end;
  logic last_square;
  logic shift_exp;
  logic reload_exp;
  logic underrun_set;

  exponent_prefetch_buffer #(
    .WIDTH(REGISTER_SIZE)
  ) u_exp_buf (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .word      (exponent_block_in),
    .word_valid(exponent_valid_in),
    .word_ready(exponent_ready_out),
    .shift     (shift_exp),
    .reload    (reload_exp),
    .cur_lsb   (cur_lsb),
    .cur_full  (cur_full),
    .next_full (next_full)
  );

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    shift_exp    = 1'b0;
    reload_exp   = 1'b0;
    underrun_set = 1'b0;
    // An empty cur_word (after an underrun) reads as zero bits.
    sel_bit      = cur_lsb & cur_full;
    value_end    = (block_ctr == BLK_LAST);
    word_end     = (bit_ctr == BIT_LAST);
    last_square  = (square_ctr == SQ_LAST);
    case (state)
      WAIT_EXP: begin
        if (square_valid_in) underrun_set = 1'b1;
        if (cur_full) state_next = STREAM;
      end
      STREAM: begin
        if (square_valid_in) begin
          accept = 1'b1;
          if (value_end) begin
            shift_exp = 1'b1;
            if (word_end) begin
              reload_exp = 1'b1;
              // Running dry after the final word is the normal end.
              if (!next_full && !last_square) underrun_set = 1'b1;
            end
            if (last_square) state_next = DONE;
          end
        end
      end
      DONE:    state_next = WAIT_EXP;
      default: state_next = WAIT_EXP;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                 <= WAIT_EXP;
      block_ctr             <= '0;
      bit_ctr               <= '0;
      square_ctr            <= '0;
      any_acc               <= 1'b0;
      selected_block_out    <= '0;
      selected_valid_out    <= 1'b0;
      selected_last_out     <= 1'b0;
      done_out              <= 1'b0;
      any_selected_out      <= 1'b0;
      exponent_underrun_out <= 1'b0;
    end else begin
      state              <= state_next;
      selected_valid_out <= 1'b0;
      selected_last_out  <= 1'b0;
      done_out           <= 1'b0;
      if (underrun_set) exponent_underrun_out <= 1'b1;
      if (accept) begin
        selected_block_out <= square_block_in;
        selected_valid_out <= sel_bit;
        selected_last_out  <= sel_bit & value_end;
        if (value_end) begin
          block_ctr <= '0;
          bit_ctr   <= word_end ? '0 : bit_ctr + 1'b1;
          if (last_square) begin
            square_ctr       <= '0;
            done_out         <= 1'b1;
            any_selected_out <= any_acc | sel_bit;
            any_acc          <= 1'b0;
          end else begin
            square_ctr <= square_ctr + 1'b1;
            any_acc    <= any_acc | sel_bit;
          end
        end else begin
          block_ctr <= block_ctr + 1'b1;
        end
      end
    end
  end

endmodule
